// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter.
// Owner encoding doubles as the FSM state encoding.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_DAT = 2'd1,
        GNT_INS = 2'd2
    } arb_state_t;

    localparam logic [1:0] OWNER_IDLE = 2'd0;
    localparam logic [1:0] OWNER_DAT  = 2'd1;
    localparam logic [1:0] OWNER_INS  = 2'd2;

    function automatic int wdog_width(int t);
        int w;
        w = $clog2(t + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/wb_arbiter2_if.sv
// Bus bundle between the two core masters, the arbiter and the slave.
// The slave modport is the arbiter's view; master is the environment's.
interface wb_arbiter2_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    localparam int SWIDTH = DWIDTH / 8;

    logic              dat_cyc_i;
    logic              dat_we_i;
    logic [SWIDTH-1:0] dat_sel_i;
    logic [AWIDTH-1:0] dat_adr_i;
    logic [DWIDTH-1:0] dat_dat_i;
    logic              dat_ack_o;
    logic              dat_err_o;
    logic              ins_cyc_i;
    logic [AWIDTH-1:0] ins_adr_i;
    logic              ins_ack_o;
    logic              ins_err_o;
    logic [DWIDTH-1:0] m_dat_o;
    logic              s_cyc_o;
    logic              s_stb_o;
    logic              s_we_o;
    logic [SWIDTH-1:0] s_sel_o;
    logic [AWIDTH-1:0] s_adr_o;
    logic [DWIDTH-1:0] s_dat_o;
    logic [DWIDTH-1:0] s_dat_i;
    logic              s_ack_i;
    logic [1:0]        owner_o;

    modport slave (
        input  dat_cyc_i, dat_we_i, dat_sel_i,
        input  dat_adr_i, dat_dat_i,
        input  ins_cyc_i, ins_adr_i,
        input  s_dat_i, s_ack_i,
        output dat_ack_o, dat_err_o,
        output ins_ack_o, ins_err_o,
        output m_dat_o,
        output s_cyc_o, s_stb_o, s_we_o,
        output s_sel_o, s_adr_o, s_dat_o,
        output owner_o
    );

    modport master (
        output dat_cyc_i, dat_we_i, dat_sel_i,
        output dat_adr_i, dat_dat_i,
        output ins_cyc_i, ins_adr_i,
        output s_dat_i, s_ack_i,
        input  dat_ack_o, dat_err_o,
        input  ins_ack_o, ins_err_o,
        input  m_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o,
        input  s_sel_o, s_adr_o, s_dat_o,
        input  owner_o
    );

endinterface

// File: rtl/wb_arb_watchdog.sv
// Ack watchdog: counts granted cycles without ack and flags when the
// count reaches TIMEOUT. Only built with WB_ARB_TIMEOUT_EN.
module wb_arb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic active_i,
    input  logic clear_i,
    output logic expired_o
);
    localparam int CW = wdog_width(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !active_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = active_i && (cnt_q == CW'(TIMEOUT));

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master (ifetch/mem) to one-slave Wishbone arbiter, round-robin.
// Define WB_ARB_TIMEOUT_EN to add the ack watchdog and err outputs.
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    wb_arbiter2_if.slave bus
);
    localparam int SWIDTH = DWIDTH / 8;

    arb_state_t state_q, state_d;
    logic       last_ins_q, last_ins_d;
    logic       own_cyc;
    logic       timeout;

    logic              s_cyc;
    logic              s_we;
    logic [SWIDTH-1:0] s_sel;
    logic [AWIDTH-1:0] s_adr;
    logic [DWIDTH-1:0] s_dat;
    logic              dat_ack, ins_ack;
    logic              dat_err, ins_err;
    logic [1:0]        owner;

    always_comb begin
        own_cyc = 1'b0;
        unique case (state_q)
            GNT_DAT: own_cyc = bus.dat_cyc_i;
            GNT_INS: own_cyc = bus.ins_cyc_i;
            default: own_cyc = 1'b0;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic wd_expired;
    logic wd_clear;

    assign wd_clear = (state_d != state_q) || bus.s_ack_i;

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .active_i  (state_q != IDLE),
        .clear_i   (wd_clear),
        .expired_o (wd_expired)
    );

    // An ack landing on the expiry cycle still wins over the abort.
    assign timeout = wd_expired && own_cyc && !bus.s_ack_i;
`else
    if (TIMEOUT < 0) begin : g_no_watchdog
    end
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        last_ins_d = last_ins_q;
        unique case (state_q)
            IDLE: begin
                if (bus.dat_cyc_i && bus.ins_cyc_i) begin
                    state_d = last_ins_q ? GNT_DAT : GNT_INS;
                end else if (bus.dat_cyc_i) begin
                    state_d = GNT_DAT;
                end else if (bus.ins_cyc_i) begin
                    state_d = GNT_INS;
                end
            end
            GNT_DAT: begin
                if (timeout) begin
                    state_d    = IDLE;
                    last_ins_d = 1'b0;
                end else if (!bus.dat_cyc_i) begin
                    last_ins_d = 1'b0;
                    state_d    = bus.ins_cyc_i ? GNT_INS : IDLE;
                end
            end
            GNT_INS: begin
                if (timeout) begin
                    state_d    = IDLE;
                    last_ins_d = 1'b1;
                end else if (!bus.ins_cyc_i) begin
                    last_ins_d = 1'b1;
                    state_d    = bus.dat_cyc_i ? GNT_DAT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            last_ins_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_ins_q <= last_ins_d;
        end
    end

    always_comb begin
        s_cyc   = 1'b0;
        s_we    = 1'b0;
        s_sel   = '0;
        s_adr   = '0;
        s_dat   = '0;
        dat_ack = 1'b0;
        ins_ack = 1'b0;
        dat_err = 1'b0;
        ins_err = 1'b0;
        owner   = OWNER_IDLE;
        unique case (state_q)
            GNT_DAT: begin
                owner   = OWNER_DAT;
                s_cyc   = bus.dat_cyc_i && !timeout;
                s_we    = bus.dat_we_i;
                s_sel   = bus.dat_sel_i;
                s_adr   = bus.dat_adr_i;
                s_dat   = bus.dat_dat_i;
                dat_ack = bus.dat_cyc_i && bus.s_ack_i;
                dat_err = timeout;
            end
            GNT_INS: begin
                owner   = OWNER_INS;
                s_cyc   = bus.ins_cyc_i && !timeout;
                s_sel   = '1;
                s_adr   = bus.ins_adr_i;
                ins_ack = bus.ins_cyc_i && bus.s_ack_i;
                ins_err = timeout;
            end
            default: owner = OWNER_IDLE;
        endcase
    end

    assign bus.s_cyc_o   = s_cyc;
    assign bus.s_stb_o   = s_cyc;
    assign bus.s_we_o    = s_we;
    assign bus.s_sel_o   = s_sel;
    assign bus.s_adr_o   = s_adr;
    assign bus.s_dat_o   = s_dat;
    assign bus.dat_ack_o = dat_ack;
    assign bus.ins_ack_o = ins_ack;
    assign bus.dat_err_o = dat_err;
    assign bus.ins_err_o = ins_err;
    assign bus.m_dat_o   = bus.s_dat_i;
    assign bus.owner_o   = owner;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed scenarios plus random traffic,
// all checked every cycle against a transaction-level owner model.
module tb_wb_arbiter2;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    wb_arbiter2_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

    wb_arbiter2 #(
        .AWIDTH  (32),
        .DWIDTH  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic cmp(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: who owns the bus (0/1/2), who had it last, idle cycles.
    int m_own;
    int m_last;
    int m_cnt;
    bit m_ok = 1'b0;

    function automatic bit m_owncyc(int o);
        if (o == 1) return bus.dat_cyc_i;
        if (o == 2) return bus.ins_cyc_i;
        return 1'b0;
    endfunction

    function automatic bit m_expire(int o, int c);
`ifdef WB_ARB_TIMEOUT_EN
        return (o != 0) && m_owncyc(o) && !bus.s_ack_i && (c == TO);
`else
        return (o < 0) && (c < 0);
`endif
    endfunction

    always @(posedge clk) begin : model
        int  nxt;
        int  nl;
        bit  oc;
        oc  = m_owncyc(m_own);
        nxt = m_own;
        nl  = m_last;
        if (m_own == 0) begin
            if (bus.dat_cyc_i && bus.ins_cyc_i)
                nxt = (m_last == 2) ? 1 : 2;
            else if (bus.dat_cyc_i)
                nxt = 1;
            else if (bus.ins_cyc_i)
                nxt = 2;
        end else if (m_expire(m_own, m_cnt)) begin
            nl  = m_own;
            nxt = 0;
        end else if (!oc) begin
            nl  = m_own;
            nxt = m_owncyc(3 - m_own) ? 3 - m_own : 0;
        end
        if (rst) begin
            m_own  <= 0;
            m_last <= 2;
            m_cnt  <= 0;
            m_ok   <= 1'b1;
        end else begin
            m_own  <= nxt;
            m_last <= nl;
            if (nxt != m_own || bus.s_ack_i || m_own == 0)
                m_cnt <= 0;
            else
                m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin : check
        bit         oc;
        bit         ex;
        logic [3:0] sel;
        if (m_ok) begin
            oc  = m_owncyc(m_own);
            ex  = m_expire(m_own, m_cnt);
            sel = (m_own == 1) ? bus.dat_sel_i :
                  (m_own == 2) ? 4'hF : 4'h0;
            cmp("owner", 64'(bus.owner_o), 64'(m_own));
            cmp("s_cyc", 64'(bus.s_cyc_o), 64'(oc && !ex));
            cmp("s_stb", 64'(bus.s_stb_o), 64'(oc && !ex));
            cmp("s_we", 64'(bus.s_we_o),
                64'(m_own == 1 && bus.dat_we_i));
            cmp("s_sel", 64'(bus.s_sel_o), 64'(sel));
            cmp("s_adr", 64'(bus.s_adr_o),
                64'((m_own == 1) ? bus.dat_adr_i :
                    (m_own == 2) ? bus.ins_adr_i : 32'h0));
            cmp("s_dat", 64'(bus.s_dat_o),
                64'((m_own == 1) ? bus.dat_dat_i : 32'h0));
            cmp("dat_ack", 64'(bus.dat_ack_o),
                64'(m_own == 1 && oc && bus.s_ack_i));
            cmp("ins_ack", 64'(bus.ins_ack_o),
                64'(m_own == 2 && oc && bus.s_ack_i));
            cmp("dat_err", 64'(bus.dat_err_o), 64'(ex && m_own == 1));
            cmp("ins_err", 64'(bus.ins_err_o), 64'(ex && m_own == 2));
            cmp("m_dat", 64'(bus.m_dat_o), 64'(bus.s_dat_i));
        end
    end

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int g[$];
    int dn_d, dn_i, prev;
    bit seen_d, seen_i;

    initial begin
        rst           = 1'b1;
        bus.dat_cyc_i = 0;
        bus.dat_we_i  = 0;
        bus.dat_sel_i = 0;
        bus.dat_adr_i = 0;
        bus.dat_dat_i = 0;
        bus.ins_cyc_i = 0;
        bus.ins_adr_i = 0;
        bus.s_ack_i   = 0;
        bus.s_dat_i   = 32'hCAFEF00D;
        tick();
        @(negedge clk);
        cmp("rst_owner", 64'(bus.owner_o), 64'd0);
        cmp("rst_s_cyc", 64'(bus.s_cyc_o), 64'd0);
        cmp("rst_s_sel", 64'(bus.s_sel_o), 64'd0);
        tick();
        rst = 1'b0;

        // Single data write
        tick();
        bus.dat_cyc_i = 1;
        bus.dat_we_i  = 1;
        bus.dat_adr_i = 32'h100;
        bus.dat_dat_i = 32'hDEADBEEF;
        bus.dat_sel_i = 4'hF;
        @(negedge clk);
        cmp("t1_c0_cyc", 64'(bus.s_cyc_o), 64'd0);
        tick();
        @(negedge clk);
        cmp("t1_c1_owner", 64'(bus.owner_o), 64'd1);
        cmp("t1_c1_cyc", 64'(bus.s_cyc_o), 64'd1);
        cmp("t1_c1_adr", 64'(bus.s_adr_o), 64'h100);
        cmp("t1_c1_dat", 64'(bus.s_dat_o), 64'hDEADBEEF);
        tick();
        bus.s_ack_i = 1;
        @(negedge clk);
        cmp("t1_c2_ack", 64'(bus.dat_ack_o), 64'd1);
        cmp("t1_c2_iack", 64'(bus.ins_ack_o), 64'd0);
        tick();
        bus.s_ack_i   = 0;
        bus.dat_cyc_i = 0;
        @(negedge clk);
        cmp("t1_c3_cyc", 64'(bus.s_cyc_o), 64'd0);
        tick();
        @(negedge clk);
        cmp("t1_c4_owner", 64'(bus.owner_o), 64'd0);

        // Simultaneous requests after reset: data first, direct handoff
        do_reset();
        tick();
        bus.dat_cyc_i = 1;
        bus.ins_cyc_i = 1;
        bus.ins_adr_i = 32'h200;
        tick();
        @(negedge clk);
        cmp("t2_first", 64'(bus.owner_o), 64'd1);
        cmp("t2_we", 64'(bus.s_we_o), 64'd1);
        tick();
        bus.s_ack_i = 1;
        tick();
        bus.s_ack_i   = 0;
        bus.dat_cyc_i = 0;
        tick();
        @(negedge clk);
        cmp("t2_handoff", 64'(bus.owner_o), 64'd2);
        cmp("t2_ins_we", 64'(bus.s_we_o), 64'd0);
        cmp("t2_ins_sel", 64'(bus.s_sel_o), 64'hF);
        cmp("t2_ins_adr", 64'(bus.s_adr_o), 64'h200);
        tick();
        bus.s_ack_i = 1;
        @(negedge clk);
        cmp("t2_ins_ack", 64'(bus.ins_ack_o), 64'd1);
        tick();
        bus.s_ack_i   = 0;
        bus.ins_cyc_i = 0;
        tick();

        // Abort: ins drops cyc, late ack is swallowed
        tick();
        bus.ins_cyc_i = 1;
        bus.ins_adr_i = 32'h300;
        tick();
        @(negedge clk);
        cmp("ab_owner", 64'(bus.owner_o), 64'd2);
        tick();
        bus.ins_cyc_i = 0;
        @(negedge clk);
        cmp("ab_cyc", 64'(bus.s_cyc_o), 64'd0);
        tick();
        bus.s_ack_i = 1;
        @(negedge clk);
        cmp("ab_idle", 64'(bus.owner_o), 64'd0);
        cmp("ab_iack", 64'(bus.ins_ack_o), 64'd0);
        cmp("ab_dack", 64'(bus.dat_ack_o), 64'd0);
        tick();
        bus.s_ack_i = 0;

        // Sync reset in the middle of a data burst
        tick();
        bus.dat_cyc_i = 1;
        tick();
        bus.s_ack_i = 1;
        tick();
        rst = 1'b1;
        @(negedge clk);
        cmp("rb_pre", 64'(bus.owner_o), 64'd1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        cmp("rb_owner", 64'(bus.owner_o), 64'd0);
        cmp("rb_cyc", 64'(bus.s_cyc_o), 64'd0);
        tick();
        @(negedge clk);
        cmp("rb_regrant", 64'(bus.owner_o), 64'd1);
        tick();
        bus.dat_cyc_i = 0;
        bus.s_ack_i   = 0;
        tick();

        // Round-robin with both masters always asking
        do_reset();
        tick();
        bus.s_ack_i   = 1;
        bus.dat_cyc_i = 1;
        bus.ins_cyc_i = 1;
        dn_d = 0;
        dn_i = 0;
        prev = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            seen_d = bus.dat_ack_o;
            seen_i = bus.ins_ack_o;
            if (bus.owner_o != 0 && int'(bus.owner_o) != prev)
                g.push_back(int'(bus.owner_o));
            prev = int'(bus.owner_o);
            tick();
            if (seen_d) begin
                bus.dat_cyc_i = 0;
                dn_d++;
            end else begin
                bus.dat_cyc_i = (dn_d < 3);
            end
            if (seen_i) begin
                bus.ins_cyc_i = 0;
                dn_i++;
            end else begin
                bus.ins_cyc_i = (dn_i < 3);
            end
        end
        bus.s_ack_i = 0;
        cmp("rr_grants", 64'(g.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            cmp("rr_order", 64'((i < g.size()) ? g[i] : 0),
                64'((i % 2 == 0) ? 1 : 2));

        // Silent slave: data request never acked, ins waiting behind it
        do_reset();
        tick();
        bus.dat_cyc_i = 1;
        bus.dat_adr_i = 32'h400;
        tick();
        tick();
        bus.ins_cyc_i = 1;
        tick();
        tick();
        @(negedge clk);
        cmp("to_c4_err", 64'(bus.dat_err_o), 64'd0);
        tick();
        @(negedge clk);
`ifdef WB_ARB_TIMEOUT_EN
        cmp("to_err", 64'(bus.dat_err_o), 64'd1);
        cmp("to_cyc", 64'(bus.s_cyc_o), 64'd0);
`else
        cmp("to_err", 64'(bus.dat_err_o), 64'd0);
        cmp("to_cyc", 64'(bus.s_cyc_o), 64'd1);
`endif
        tick();
        @(negedge clk);
        cmp("to_err_once", 64'(bus.dat_err_o), 64'd0);
        tick();
        @(negedge clk);
`ifdef WB_ARB_TIMEOUT_EN
        cmp("to_next", 64'(bus.owner_o), 64'd2);
`else
        cmp("to_next", 64'(bus.owner_o), 64'd1);
`endif
        tick();
        bus.dat_cyc_i = 0;
        bus.ins_cyc_i = 0;
        tick();

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            tick();
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 4) == 0)
                bus.dat_cyc_i = ~bus.dat_cyc_i;
            if ($urandom_range(0, 4) == 0)
                bus.ins_cyc_i = ~bus.ins_cyc_i;
            bus.dat_we_i  = 1'($urandom_range(0, 1));
            bus.dat_sel_i = 4'($urandom);
            bus.dat_adr_i = $urandom;
            bus.dat_dat_i = $urandom;
            bus.ins_adr_i = $urandom;
            bus.s_ack_i   = 1'($urandom_range(0, 1));
            bus.s_dat_i   = $urandom;
        end
        tick();
        rst = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
